// File: rtl/hd_program_loader_pkg.sv
// Shared types and geometry constants for the HD-to-instruction-memory loader.
package hd_program_loader_pkg;
   localparam int SECTORS_PER_TRACK = 16;
   localparam int TOTAL_SECTORS     = 16384;
   localparam int MI_DEPTH          = 4096;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      WRITE,
      FINISH,
      FAIL
   } state_t;
endpackage

// File: rtl/hd_address_counter.sv
// Track/sector/memory-address position for the copy.
// Loaded on an accepted start, stepped once per written word.
module hd_address_counter
   import hd_program_loader_pkg::*;
#(
   parameter int TRACK_W  = 10,
   parameter int SECTOR_W = 4,
   parameter int ADDR_W   = 12
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                load,
   input  logic                advance,
   input  logic [TRACK_W-1:0]  track_init,
   input  logic [SECTOR_W-1:0] sector_init,
   input  logic [ADDR_W-1:0]   addr_init,
   output logic [TRACK_W-1:0]  track,
   output logic [SECTOR_W-1:0] sector,
   output logic [ADDR_W-1:0]   addr
);

   localparam logic [SECTOR_W-1:0] LAST_SECTOR =
      SECTOR_W'(SECTORS_PER_TRACK - 1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         track  <= '0;
         sector <= '0;
         addr   <= '0;
      end else if (load) begin
         track  <= track_init;
         sector <= sector_init;
         addr   <= addr_init;
      end else if (advance) begin
         addr <= addr + ADDR_W'(1);
         if (sector == LAST_SECTOR) begin
            sector <= '0;
            track  <= track + TRACK_W'(1);
         end else begin
            sector <= sector + SECTOR_W'(1);
         end
      end
   end

endmodule

// File: rtl/hd_program_loader.sv
// Copies a run of HD sectors into instruction memory, one word per 3 cycles.
// All outputs come from registers or a decode of the state register.
module hd_program_loader
   import hd_program_loader_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 12,
   parameter int TRACK_W  = 10,
   parameter int SECTOR_W = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [TRACK_W-1:0]  src_track,
   input  logic [SECTOR_W-1:0] src_sector,
   input  logic [ADDR_W-1:0]   dst_addr,
   input  logic [ADDR_W:0]     length,
   input  logic [DATA_W-1:0]   hd_data,
   output logic                hd_read_en,
   output logic [TRACK_W-1:0]  hd_track,
   output logic [SECTOR_W-1:0] hd_sector,
   output logic                mi_write_en,
   output logic [ADDR_W-1:0]   mi_addr,
   output logic [DATA_W-1:0]   mi_data,
   output logic                busy,
   output logic                done,
   output logic                error
);

   state_t              state_q;
   state_t              state_d;
   logic [ADDR_W:0]     remaining;
   logic [DATA_W-1:0]   data_q;
   logic                error_q;
   logic                accept;
   logic                advance;
   logic                range_err;
   logic [31:0]         dst_end;
   logic [31:0]         sec_end;

   assign accept  = (state_q == IDLE) && start;
   assign advance = (state_q == WRITE) && !abort;

   // Full-width sums so an oversize request can never wrap into range.
   assign dst_end = 32'(dst_addr) + 32'(length);
   assign sec_end = 32'(src_track) * 32'(SECTORS_PER_TRACK)
                  + 32'(src_sector) + 32'(length);
   assign range_err = (dst_end > 32'(MI_DEPTH))
                   || (sec_end > 32'(TOTAL_SECTORS));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (length == '0)   state_d = FINISH;
               else if (range_err) state_d = FAIL;
               else                state_d = REQ;
            end
         end
         REQ:   state_d = WAIT;
         WAIT:  state_d = WRITE;
         WRITE: begin
            if (remaining == (ADDR_W+1)'(1)) state_d = FINISH;
            else                             state_d = REQ;
         end
         FINISH:  state_d = IDLE;
         FAIL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && (state_q != IDLE)) state_d = IDLE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         remaining <= '0;
         data_q    <= '0;
         error_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            remaining <= length;
            error_q   <= (length != '0) && range_err;
         end
         if (state_q == WAIT) data_q <= hd_data;
         if (advance) remaining <= remaining - (ADDR_W+1)'(1);
      end
   end

   hd_address_counter #(
      .TRACK_W  (TRACK_W),
      .SECTOR_W (SECTOR_W),
      .ADDR_W   (ADDR_W)
   ) u_addr (
      .clock       (clock),
      .reset       (reset),
      .load        (accept),
      .advance     (advance),
      .track_init  (src_track),
      .sector_init (src_sector),
      .addr_init   (dst_addr),
      .track       (hd_track),
      .sector      (hd_sector),
      .addr        (mi_addr)
   );

   assign hd_read_en  = (state_q == REQ);
   assign mi_write_en = (state_q == WRITE);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == FINISH) || (state_q == FAIL);
   assign error       = error_q;
   assign mi_data     = data_q;

endmodule
